// File: rtl/alert_qual.sv
// Alert qualifier for the piezo driver: averages battery samples into a low-battery
// alert with hysteresis, and persistence-qualifies wheel speeds into an over-speed alert.
module alert_qual #(
    parameter logic [11:0] BATT_THRES = 12'hA98,
    parameter logic [11:0] BATT_HYST  = 12'h040,
    parameter logic [11:0] FAST_THRES = 12'd1792,
    parameter logic [11:0] FAST_HYST  = 12'd128,
    parameter int unsigned FAST_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        batt_vld,
    input  logic [11:0] batt,
    input  logic        spd_vld,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        en_steer_in,
    output logic        too_fast,
    output logic        batt_low,
    output logic        en_steer
);

    // Thresholds widened to 13 bits so the clear level cannot wrap.
    localparam logic [12:0]        BATT_SET   = {1'b0, BATT_THRES};
    localparam logic [12:0]        BATT_CLR   = {1'b0, BATT_THRES} + {1'b0, BATT_HYST};
    localparam logic signed [11:0] FAST_SET   = $signed(FAST_THRES);
    localparam logic signed [11:0] FAST_CLR   = $signed(FAST_THRES - FAST_HYST);
    localparam logic [3:0]         FAST_CNT_L = 4'(FAST_CNT);

    // ------------------------------------------------------------------
    // Battery path: 8-sample boxcar average, then hysteretic compare
    // ------------------------------------------------------------------
    logic [14:0] sum;
    logic [2:0]  smp_cnt;
    logic [11:0] avg;
    logic        avg_done;
    logic [14:0] sum_total;

    assign sum_total = sum + {3'b000, batt};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            smp_cnt  <= '0;
            avg      <= '0;
            avg_done <= 1'b0;
        end else begin
            avg_done <= 1'b0;
            if (batt_vld) begin
                if (smp_cnt == 3'd7) begin
                    // The 8th sample joins the average directly, so nothing is lost.
                    avg      <= sum_total[14:3];
                    avg_done <= 1'b1;
                    sum      <= '0;
                    smp_cnt  <= '0;
                end else begin
                    sum     <= sum_total;
                    smp_cnt <= smp_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batt_low <= 1'b0;
        end else if (avg_done) begin
            if ({1'b0, avg} < BATT_SET) begin
                batt_low <= 1'b1;
            end else if ({1'b0, avg} >= BATT_CLR) begin
                batt_low <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Speed path: persistence FSM evaluated on each speed strobe
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ARMING = 2'd1,
        FAST   = 2'd2
    } spd_state_t;

    spd_state_t state, state_nxt;
    logic [3:0] pcnt, pcnt_nxt, pcnt_inc;
    logic       over_spd;
    logic       calm_spd;

    // Negative speeds compare below any positive threshold, so reversing never alerts.
    assign over_spd = ($signed(lft_spd) > FAST_SET) || ($signed(rght_spd) > FAST_SET);
    assign calm_spd = ($signed(lft_spd) <= FAST_CLR) && ($signed(rght_spd) <= FAST_CLR);
    assign pcnt_inc = pcnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NORMAL;
            pcnt     <= '0;
            too_fast <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcnt     <= pcnt_nxt;
            too_fast <= (state_nxt == FAST);
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        if (spd_vld) begin
            case (state)
                NORMAL: begin
                    if (over_spd) begin
                        pcnt_nxt  = 4'd1;
                        state_nxt = (FAST_CNT_L <= 4'd1) ? FAST : ARMING;
                    end
                end
                ARMING: begin
                    if (over_spd) begin
                        pcnt_nxt = pcnt_inc;
                        if (pcnt_inc >= FAST_CNT_L) begin
                            state_nxt = FAST;
                        end
                    end else begin
                        pcnt_nxt  = '0;
                        state_nxt = NORMAL;
                    end
                end
                FAST: begin
                    if (calm_spd) begin
                        pcnt_nxt  = '0;
                        state_nxt = NORMAL;
                    end
                end
                default: begin
                    pcnt_nxt  = '0;
                    state_nxt = NORMAL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Steering status, delayed one clock to line up with the alert flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_steer <= 1'b0;
        end else begin
            en_steer <= en_steer_in;
        end
    end

endmodule

// File: tb/tb_alert_qual.sv
// Directed bench for alert_qual: a vector table checked after every clock edge,
// plus hand-written reset sequences for partial averages and partial arming.
module tb_alert_qual;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        batt_vld;
    logic [11:0] batt;
    logic        spd_vld;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        en_steer_in;
    logic        too_fast;
    logic        batt_low;
    logic        en_steer;

    localparam logic [11:0] S1800  = 12'd1800;
    localparam logic [11:0] S1900  = 12'd1900;
    localparam logic [11:0] S1792  = 12'd1792;
    localparam logic [11:0] S1700  = 12'd1700;
    localparam logic [11:0] S1664  = 12'd1664;
    localparam logic [11:0] S1600  = 12'd1600;
    localparam logic [11:0] SN2000 = 12'd2096;   // -2000 in 12-bit two's complement

    alert_qual dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .batt_vld   (batt_vld),
        .batt       (batt),
        .spd_vld    (spd_vld),
        .lft_spd    (lft_spd),
        .rght_spd   (rght_spd),
        .en_steer_in(en_steer_in),
        .too_fast   (too_fast),
        .batt_low   (batt_low),
        .en_steer   (en_steer)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        bv;
        logic [11:0] b;
        logic        sv;
        logic [11:0] l;
        logic [11:0] r;
        logic        en;
        logic        tf;
        logic        bl;
    } vec_t;

    vec_t vecs[$];
    logic pend_rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // en_steer_in follows a fixed irregular pattern so the delay path is exercised.
    task automatic add(input logic bv, input logic [11:0] b, input logic sv,
                       input logic [11:0] l, input logic [11:0] r,
                       input logic tf, input logic bl);
        vec_t v;
        v.rst = pend_rst;
        v.bv  = bv;
        v.b   = b;
        v.sv  = sv;
        v.l   = l;
        v.r   = r;
        v.en  = (vecs.size() % 3) != 0;
        v.tf  = tf;
        v.bl  = bl;
        vecs.push_back(v);
        pend_rst = 1'b0;
    endtask

    task automatic drive(input logic bv, input logic [11:0] b, input logic sv,
                         input logic [11:0] l, input logic [11:0] r, input logic en);
        batt_vld    = bv;
        batt        = b;
        spd_vld     = sv;
        lft_spd     = l;
        rght_spd    = r;
        en_steer_in = en;
    endtask

    task automatic step(input logic bv, input logic [11:0] b, input logic sv,
                        input logic [11:0] l, input logic [11:0] r, input logic en);
        @(negedge clk);
        drive(bv, b, sv, l, r, en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic fill_table();
        // Coincident strobes every cycle: too_fast on the 4th, batt_low after the 8th.
        for (int i = 0; i < 16; i++)
            add(1'b1, 12'h900, 1'b1, S1900, 12'h000, i >= 3, i >= 8);

        // Eight 0xA00 samples: batt_low stays 0 through the 8th strobe, then sets.
        pend_rst = 1'b1;
        for (int i = 0; i < 8; i++)
            add(1'b1, 12'hA00, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        add(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        // Average 0xAB0 sits inside the hysteresis band: hold.
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 12'hAB0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
            add(1'b0, 12'hFFF, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        end
        // Average 0xAE0 clears; an idle gap mid-average must not disturb it.
        for (int i = 0; i < 3; i++)
            add(1'b1, 12'hAE0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(1'b1, 12'hAE0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
        add(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);

        // Four over-speed samples on the left wheel.
        for (int i = 0; i < 4; i++)
            add(1'b0, 12'h000, 1'b1, S1800, 12'h000, i == 3, 1'b0);
        add(1'b0, 12'h000, 1'b1, S1700, 12'h000, 1'b1, 1'b0);       // above clear level
        add(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0);     // no strobe: ignored
        add(1'b0, 12'h000, 1'b1, S1600, S1664, 1'b0, 1'b0);         // both at/below clear
        // Three over-speed then a non-over-speed sample resets the count.
        for (int i = 0; i < 3; i++)
            add(1'b0, 12'h000, 1'b1, S1800, 12'h000, 1'b0, 1'b0);
        add(1'b0, 12'h000, 1'b1, S1700, 12'h000, 1'b0, 1'b0);
        add(1'b0, 12'h000, 1'b1, S1800, 12'h000, 1'b0, 1'b0);
        add(1'b0, 12'h000, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0);
        // Right wheel alone qualifies; negative left wheel is irrelevant.
        for (int i = 0; i < 4; i++)
            add(1'b0, 12'h000, 1'b1, SN2000, S1800, i == 3, 1'b0);
        add(1'b0, 12'h000, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0);
        // Exactly at threshold is not over-speed.
        for (int i = 0; i < 6; i++)
            add(1'b0, 12'h000, 1'b1, S1792, S1792, 1'b0, 1'b0);
        // Large negative speeds never alert.
        for (int i = 0; i < 6; i++)
            add(1'b0, 12'h000, 1'b1, SN2000, SN2000, 1'b0, 1'b0);
        // Idle cycles between strobes do not break persistence.
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 12'h000, 1'b1, S1800, 12'h000, 1'b0, 1'b0);
            add(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
        end
        add(1'b0, 12'h000, 1'b1, S1800, 12'h000, 1'b1, 1'b0);
        add(1'b0, 12'h000, 1'b1, S1664, S1664, 1'b0, 1'b0);         // clear boundary
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        #1;
        check("reset too_fast", too_fast, 1'b0);
        check("reset batt_low", batt_low, 1'b0);
        check("reset en_steer", en_steer, 1'b0);
        #14;
        rst_n = 1'b1;

        fill_table();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].bv, vecs[i].b, vecs[i].sv, vecs[i].l, vecs[i].r, vecs[i].en);
            check($sformatf("vec%0d too_fast", i), too_fast, vecs[i].tf);
            check($sformatf("vec%0d batt_low", i), batt_low, vecs[i].bl);
            check($sformatf("vec%0d en_steer", i), en_steer, vecs[i].en);
        end

        // Asynchronous reset while both alerts are active.
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 12'hA00, i < 4, S1800, 12'h000, 1'b1);
        step(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1);
        check("pre-reset too_fast", too_fast, 1'b1);
        check("pre-reset batt_low", batt_low, 1'b1);
        check("pre-reset en_steer", en_steer, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async too_fast", too_fast, 1'b0);
        check("async batt_low", batt_low, 1'b0);
        check("async en_steer", en_steer, 1'b0);
        #3;
        rst_n = 1'b1;

        // Reset mid-arming and mid-average (zero samples): counts restart.
        for (int i = 0; i < 3; i++)
            step(1'b1, 12'h000, 1'b1, S1800, 12'h000, 1'b0);
        step(1'b1, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        check("armed3 too_fast", too_fast, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'hAE0, 1'b1, S1800, 12'h000, 1'b0);
            check($sformatf("rearm%0d too_fast", i), too_fast, i == 3);
        end
        step(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        check("fresh cnt batt_low", batt_low, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 12'hAE0, 1'b0, 12'h000, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        check("fresh avg batt_low", batt_low, 1'b0);

        // Reset mid-average with full-scale samples: partial sum must be discarded.
        for (int i = 0; i < 4; i++)
            step(1'b1, 12'hFFF, 1'b0, 12'h000, 12'h000, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 12'hAE0, 1'b0, 12'h000, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
        check("fresh sum batt_low", batt_low, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
